// File: rtl/cfg_frame_sequencer_if.sv
// Byte-stream and config-write bundle between the link receiver, the frame
// sequencer and the config register file.
interface cfg_frame_sequencer_if;
    logic [7:0]  byte_in;
    logic        byte_vld_in;
    logic        wr_out;
    logic [7:0]  wr_addr_out;
    logic [15:0] data_out;
    logic        seq_busy_out;
    logic [15:0] frame_ok_cnt_out;
    logic [15:0] frame_err_cnt_out;
    logic [1:0]  last_err_out;

    modport master (
        output byte_in, byte_vld_in,
        input  wr_out, wr_addr_out, data_out, seq_busy_out,
        input  frame_ok_cnt_out, frame_err_cnt_out, last_err_out
    );

    modport slave (
        input  byte_in, byte_vld_in,
        output wr_out, wr_addr_out, data_out, seq_busy_out,
        output frame_ok_cnt_out, frame_err_cnt_out, last_err_out
    );
endinterface

// File: rtl/cfg_frame_sequencer.sv
// Telecommand frame parser: SYNC_HI SYNC_LO ADDR DATA_H DATA_L CHK -> one config write strobe.
// Define CFG_SEQ_TIMEOUT_EN to enable the inter-byte timeout inside a frame.
module cfg_frame_sequencer #(
    parameter logic [7:0]  SYNC_HI     = 8'hEB,
    parameter logic [7:0]  SYNC_LO     = 8'h90,
    parameter logic [7:0]  ADDR_MIN    = 8'h02,
    parameter logic [7:0]  ADDR_MAX    = 8'h15,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    cfg_frame_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC2, S_ADDR, S_DATH, S_DATL, S_CHK, S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dh_q, dh_d;
    logic [7:0]  dl_q, dl_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] ok_q, ok_d;
    logic [15:0] err_q, err_d;
    logic [1:0]  lerr_q, lerr_d;

    logic        vld;
    logic [7:0]  rx;

    assign vld = bus.byte_vld_in;
    assign rx  = bus.byte_in;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef CFG_SEQ_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        timeout;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            dh_q      <= '0;
            dl_q      <= '0;
            wr_addr_q <= '0;
            data_q    <= '0;
            ok_q      <= '0;
            err_q     <= '0;
            lerr_q    <= '0;
`ifdef CFG_SEQ_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dh_q      <= dh_d;
            dl_q      <= dl_d;
            wr_addr_q <= wr_addr_d;
            data_q    <= data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            lerr_q    <= lerr_d;
`ifdef CFG_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dh_d      = dh_q;
        dl_d      = dl_q;
        wr_addr_d = wr_addr_q;
        data_d    = data_q;
        ok_d      = ok_q;
        err_d     = err_q;
        lerr_d    = lerr_q;
`ifdef CFG_SEQ_TIMEOUT_EN
        tmo_d     = '0;
        timeout   = 1'b0;
        // Counts idle cycles since the last byte while a frame is open.
        if (!vld && (state_q inside {S_SYNC2, S_ADDR, S_DATH, S_DATL, S_CHK})) begin
            tmo_d = tmo_q + 16'd1;
            if (tmo_q == TIMEOUT_CYC - 16'd1) timeout = 1'b1;
        end
`endif

        case (state_q)
            S_IDLE, S_WRITE: begin
                // The strobe cycle also accepts the first sync byte of the next frame.
                state_d = (vld && rx == SYNC_HI) ? S_SYNC2 : S_IDLE;
            end
            S_SYNC2: begin
                if (vld) begin
                    if (rx == SYNC_LO)      state_d = S_ADDR;
                    else if (rx == SYNC_HI) state_d = S_SYNC2;
                    else                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (vld) begin
                    addr_d  = rx;
                    state_d = S_DATH;
                end
            end
            S_DATH: begin
                if (vld) begin
                    dh_d    = rx;
                    state_d = S_DATL;
                end
            end
            S_DATL: begin
                if (vld) begin
                    dl_d    = rx;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (vld) begin
                    if ((addr_q ^ dh_q ^ dl_q) != rx) begin
                        state_d = S_IDLE;
                        err_d   = sat_inc(err_q);
                        lerr_d  = 2'd1;
                    end else if (addr_q < ADDR_MIN || addr_q > ADDR_MAX) begin
                        state_d = S_IDLE;
                        err_d   = sat_inc(err_q);
                        lerr_d  = 2'd2;
                    end else begin
                        // Write outputs load on entry so they are valid during the strobe.
                        state_d   = S_WRITE;
                        wr_addr_d = addr_q;
                        data_d    = {dh_q, dl_q};
                        ok_d      = ok_q + 16'd1;
                        lerr_d    = 2'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CFG_SEQ_TIMEOUT_EN
        if (timeout) begin
            state_d = S_IDLE;
            err_d   = sat_inc(err_q);
            lerr_d  = 2'd3;
        end
`endif
    end

    assign bus.wr_out            = (state_q == S_WRITE);
    assign bus.seq_busy_out      = (state_q != S_IDLE);
    assign bus.wr_addr_out       = wr_addr_q;
    assign bus.data_out          = data_q;
    assign bus.frame_ok_cnt_out  = ok_q;
    assign bus.frame_err_cnt_out = err_q;
    assign bus.last_err_out      = lerr_q;

endmodule

// File: tb/tb_cfg_frame_sequencer.sv
// Bench for cfg_frame_sequencer: directed frame table, hand-written corner sequences,
// and random frames checked every cycle against a frame-level reference model.
module tb_cfg_frame_sequencer;

    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cfg_frame_sequencer_if bus ();

    cfg_frame_sequencer #(
        .TIMEOUT_CYC(16'(TMO))
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    // Reference model: bytes of the frame collected so far plus expected outputs.
    logic [7:0]  frm[$];
    int          gap;
    logic        m_wr, m_busy;
    logic [7:0]  m_addr;
    logic [15:0] m_data, m_ok, m_err;
    logic [1:0]  m_le;

    task automatic model_clear();
        frm.delete();
        gap = 0;
        m_wr = 0; m_busy = 0; m_addr = 0; m_data = 0;
        m_ok = 0; m_err = 0; m_le = 0;
    endtask

    task automatic model_err(input logic [1:0] code);
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_le = code;
        frm.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        m_wr = 0;
        if (v) begin
            gap = 0;
            case (frm.size())
                0: if (b == 8'hEB) frm.push_back(b);
                1: begin
                    if (b == 8'h90) frm.push_back(b);
                    else if (b != 8'hEB) frm.delete();
                end
                5: begin
                    if ((frm[2] ^ frm[3] ^ frm[4]) != b) model_err(2'd1);
                    else if (frm[2] < 8'h02 || frm[2] > 8'h15) model_err(2'd2);
                    else begin
                        m_wr = 1;
                        m_addr = frm[2];
                        m_data = {frm[3], frm[4]};
                        m_ok = m_ok + 16'd1;
                        m_le = 0;
                        frm.delete();
                    end
                end
                default: frm.push_back(b);
            endcase
        end else if (frm.size() > 0) begin
            gap++;
`ifdef CFG_SEQ_TIMEOUT_EN
            if (gap == TMO) begin
                model_err(2'd3);
                gap = 0;
            end
`endif
        end
        m_busy = (frm.size() > 0) || m_wr;
    endtask

    task automatic check(input string name);
        logic [59:0] got, exp;
        got = {bus.wr_out, bus.seq_busy_out, bus.wr_addr_out, bus.data_out,
               bus.frame_ok_cnt_out, bus.frame_err_cnt_out, bus.last_err_out};
        exp = {m_wr, m_busy, m_addr, m_data, m_ok, m_err, m_le};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got wr=%b busy=%b addr=%h data=%h ok=%0d err=%0d le=%0d, expected wr=%b busy=%b addr=%h data=%h ok=%0d err=%0d le=%0d",
                     name, $time, got[59], got[58], got[57:50], got[49:34], got[33:18], got[17:2], got[1:0],
                     exp[59], exp[58], exp[57:50], exp[49:34], exp[33:18], exp[17:2], exp[1:0]);
        end
    endtask

    // Called at a negedge: drive inputs, step model on the posedge, check on the next negedge.
    task automatic cycle(input logic v, input logic [7:0] b);
        bus.byte_vld_in = v;
        bus.byte_in = b;
        @(posedge clk);
        model_step(v, b);
        @(negedge clk);
        if (bus.wr_out === 1'b1) wr_cnt++;
        check("cycle");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.byte_vld_in = 1'b0;
        bus.byte_in = 8'h00;
        model_clear();
        #1 check("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        int          n;
        logic [55:0] bytes;
        int          wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] ok;
        logic [15:0] err;
        logic [1:0]  le;
    } row_t;

    row_t rows[9];

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                              input logic [7:0] c, input int mid_gap);
        cycle(1'b1, 8'hEB);
        cycle(1'b1, 8'h90);
        cycle(1'b1, a);
        idle(mid_gap);
        cycle(1'b1, dh);
        cycle(1'b1, dl);
        cycle(1'b1, c);
    endtask

    task automatic rand_gap();
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    endtask

    task automatic rand_frame();
        int k;
        logic [7:0] a, dh, dl, c;
        k  = $urandom_range(0, 9);
        dh = 8'($urandom);
        dl = 8'($urandom);
        if (k < 6) a = 8'($urandom_range(2, 21));
        else if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 1));
        else a = 8'($urandom_range(22, 255));
        c = a ^ dh ^ dl;
        if (k == 5) c = c ^ (8'h01 << $urandom_range(0, 7));
        if (k == 8) begin
            for (int i = 0; i < $urandom_range(1, 3); i++) begin
                cycle(1'b1, ($urandom_range(0, 2) == 0) ? 8'hEB : 8'($urandom));
                rand_gap();
            end
        end else if (k == 9) begin
            cycle(1'b1, 8'hEB); rand_gap();
            cycle(1'b1, 8'h90); rand_gap();
            cycle(1'b1, a);
`ifdef CFG_SEQ_TIMEOUT_EN
            idle(TMO - 1 + $urandom_range(0, 1));
`else
            idle($urandom_range(1, 20));
`endif
            cycle(1'b1, dh);
            cycle(1'b1, dl);
            cycle(1'b1, c);
        end else begin
            cycle(1'b1, 8'hEB); rand_gap();
            cycle(1'b1, 8'h90); rand_gap();
            cycle(1'b1, a);     rand_gap();
            cycle(1'b1, dh);    rand_gap();
            cycle(1'b1, dl);    rand_gap();
            cycle(1'b1, c);     rand_gap();
        end
    endtask

    initial begin
        int w0;
        logic [55:0] bb;

        rows[0] = '{6, 56'hEB9010_00C8D8_00, 1, 8'h10, 16'h00C8, 16'd1, 16'd0, 2'd0};
        rows[1] = '{6, 56'hEB9004_123400_00, 0, 8'h10, 16'h00C8, 16'd1, 16'd1, 2'd1};
        rows[2] = '{6, 56'hEB9020_000121_00, 0, 8'h10, 16'h00C8, 16'd1, 16'd2, 2'd2};
        rows[3] = '{7, 56'hEBEB90_020001_03, 1, 8'h02, 16'h0001, 16'd2, 16'd2, 2'd0};
        rows[4] = '{6, 56'hEB9015_ABCD73_00, 1, 8'h15, 16'hABCD, 16'd3, 16'd2, 2'd0};
        rows[5] = '{6, 56'hEB9001_000001_00, 0, 8'h15, 16'hABCD, 16'd3, 16'd3, 2'd2};
        rows[6] = '{6, 56'hEB9016_000016_00, 0, 8'h15, 16'hABCD, 16'd3, 16'd4, 2'd2};
        rows[7] = '{2, 56'hEB1200_000000_00, 0, 8'h15, 16'hABCD, 16'd3, 16'd4, 2'd2};
        rows[8] = '{6, 56'hEB9002_FFFF02_00, 1, 8'h02, 16'hFFFF, 16'd4, 16'd4, 2'd0};

        bus.byte_vld_in = 1'b0;
        bus.byte_in = 8'h00;
        @(negedge clk);
        do_reset();
        expect_val("reset_outputs",
                   {bus.wr_out, bus.seq_busy_out, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out,
                    bus.frame_err_cnt_out, bus.last_err_out}, 64'd0);

        // Directed frame table, outputs accumulate across rows.
        for (int i = 0; i < 9; i++) begin
            w0 = wr_cnt;
            bb = rows[i].bytes;
            for (int j = 0; j < rows[i].n; j++) cycle(1'b1, bb[55 - 8*j -: 8]);
            idle(2);
            expect_val($sformatf("row%0d", i),
                       {32'(wr_cnt - w0), rows[i].addr, rows[i].data[15:0], 4'h0, rows[i].le, 6'h0, bus.seq_busy_out} & 64'hFFFF_FFFF_FFFF_FFFF,
                       {32'(rows[i].wr), rows[i].addr, rows[i].data, 4'h0, rows[i].le, 6'h0, 1'b0});
            expect_val($sformatf("row%0d_regs", i),
                       {8'h0, bus.wr_addr_out, bus.data_out, bus.frame_ok_cnt_out, bus.frame_err_cnt_out[7:0], 6'h0, bus.last_err_out},
                       {8'h0, rows[i].addr, rows[i].data, rows[i].ok, rows[i].err[7:0], 6'h0, rows[i].le});
        end

        // Two frames back-to-back: second sync byte lands in the write-strobe cycle.
        w0 = wr_cnt;
        send_frame(8'h03, 8'h11, 8'h22, 8'h03 ^ 8'h11 ^ 8'h22, 0);
        send_frame(8'h04, 8'h55, 8'h66, 8'h04 ^ 8'h55 ^ 8'h66, 0);
        idle(2);
        expect_val("b2b_pulses", 64'(wr_cnt - w0), 64'd2);
        expect_val("b2b_last", {bus.wr_addr_out, bus.data_out}, {8'h04, 16'h5566});

        // Reset in the middle of a frame discards it.
        do_reset();
        w0 = wr_cnt;
        cycle(1'b1, 8'hEB); cycle(1'b1, 8'h90); cycle(1'b1, 8'h10); cycle(1'b1, 8'h00);
        do_reset();
        cycle(1'b1, 8'hC8); cycle(1'b1, 8'hD8);
        idle(3);
        expect_val("midreset",
                   {32'(wr_cnt - w0), bus.frame_ok_cnt_out, bus.frame_err_cnt_out[14:0], bus.seq_busy_out},
                   64'd0);

        // Long gap mid-frame.
        do_reset();
        w0 = wr_cnt;
`ifdef CFG_SEQ_TIMEOUT_EN
        cycle(1'b1, 8'hEB); cycle(1'b1, 8'h90); cycle(1'b1, 8'h05);
        idle(TMO - 1);
        expect_val("tmo_edge_busy", 64'(bus.seq_busy_out), 64'd1);
        idle(1);
        expect_val("tmo_fire", {bus.seq_busy_out, bus.frame_err_cnt_out, bus.last_err_out}, {1'b0, 16'd1, 2'd3});
        send_frame(8'h05, 8'h00, 8'h00, 8'h05, TMO - 1);
        idle(1);
        expect_val("tmo_accept", {32'(wr_cnt - w0), bus.wr_addr_out, bus.last_err_out}, {32'd1, 8'h05, 2'd0});
`else
        cycle(1'b1, 8'hEB); cycle(1'b1, 8'h90); cycle(1'b1, 8'h05);
        idle(TMO + 50);
        expect_val("notmo_busy", {bus.seq_busy_out, bus.frame_err_cnt_out}, {1'b1, 16'd0});
        cycle(1'b1, 8'h00); cycle(1'b1, 8'h00); cycle(1'b1, 8'h05);
        idle(1);
        expect_val("notmo_accept", {32'(wr_cnt - w0), bus.wr_addr_out, bus.last_err_out}, {32'd1, 8'h05, 2'd0});
`endif

        // Randomized frames against the model.
        do_reset();
        for (int f = 0; f < 250; f++) rand_frame();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
